fetch_sequencer: RTL and testbench

- Controls instruction fetch from the combinational instruction ROM (12-bit address, 9-bit machine code).
- Owns the program counter and an instruction register (IR) feeding decode.
- Handles start/halt, stalls, absolute and PC-relative branches with a one-bubble squash, and end-of-ROM detection.
- Sits between the top-level run control and the decoder; prog_ctr drives the ROM address directly.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_sequencer_if.sv | 32 +++
 rtl/fetch_sequencer_pc_next.sv | 21 ++
 rtl/fetch_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch sequencer.
// Imported by the sequencer, its next-PC adder and the fetch interface.
package fetch_pkg;

  localparam int D     = 12;
  localparam int IW    = 9;
  localparam int OFF_W = 8;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM address/data and decode-side bundle around the fetch sequencer.
// master = sequencer, slave = ROM plus decoder.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [D-1:0]     prog_ctr;
  logic [IW-1:0]    mach_code;
  logic [IW-1:0]    ir;
  logic             ir_valid;
  logic [D-1:0]     ir_pc;
  logic             stall;
  logic             halt;
  logic             branch_taken;
  logic             branch_abs;
  logic [D-1:0]     branch_target;
  logic [OFF_W-1:0] branch_off;

  modport master (
    output prog_ctr, ir, ir_valid, ir_pc,
    input  mach_code, stall, halt,
    input  branch_taken, branch_abs,
    input  branch_target, branch_off
  );

  modport slave (
    input  prog_ctr, ir, ir_valid, ir_pc,
    output mach_code, stall, halt,
    output branch_taken, branch_abs,
    output branch_target, branch_off
  );

endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// Next-PC arithmetic: sequential increment and branch target.
// Relative targets are taken from ir_pc and wrap modulo 2^D.
module pc_next
  import fetch_pkg::*;
(
  input  logic [D-1:0]     pc,
  input  logic [D-1:0]     ir_pc,
  input  logic             branch_abs,
  input  logic [D-1:0]     branch_target,
  input  logic [OFF_W-1:0] branch_off,
  output logic [D-1:0]     pc_inc,
  output logic [D-1:0]     target
);

  logic [D-1:0] off_ext;

  assign off_ext = {{(D-OFF_W){branch_off[OFF_W-1]}}, branch_off};
  assign pc_inc  = pc + D'(1);
  assign target  = branch_abs ? branch_target : ir_pc + off_ext;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC, IR, run control, branch squash and ROM wrap.
// prog_ctr addresses the combinational ROM directly.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [D-1:0]     start_addr,
  fetch_sequencer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             rom_wrap,
  output logic [CNT_W-1:0] retired
);

  fetch_state_t     state_q, state_d;
  logic [D-1:0]     pc_q, pc_d, irpc_q, irpc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] ret_q, ret_d, ret_inc;
  logic [D-1:0]     pc_inc, target;
  logic             fire;

  pc_next u_pc_next (
    .pc            (pc_q),
    .ir_pc         (irpc_q),
    .branch_abs    (bus.branch_abs),
    .branch_target (bus.branch_target),
    .branch_off    (bus.branch_off),
    .pc_inc        (pc_inc),
    .target        (target)
  );

  assign fire    = vld_q && !bus.stall;
  assign ret_inc = (ret_q == {CNT_W{1'b1}}) ? ret_q : ret_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irpc_d  = irpc_q;
    vld_d   = vld_q;
    done_d  = done_q;
    wrap_d  = wrap_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_addr;
          vld_d   = 1'b0;
          done_d  = 1'b0;
          wrap_d  = 1'b0;
          ret_d   = '0;
        end
      end
      RUN: begin
        // the word fetched from the last address ends the run once consumed
        if (fire && (bus.halt || wrap_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
          vld_d   = 1'b0;
          ret_d   = ret_inc;
        end else if (fire && bus.branch_taken) begin
          pc_d  = target;
          vld_d = 1'b0;
          ret_d = ret_inc;
        end else if (!bus.stall) begin
          ir_d   = bus.mach_code;
          irpc_d = pc_q;
          vld_d  = 1'b1;
          pc_d   = pc_inc;
          if (vld_q) ret_d = ret_inc;
          if (pc_q == {D{1'b1}}) wrap_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      irpc_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.prog_ctr = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = vld_q;
  assign bus.ir_pc    = irpc_q;
  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign rom_wrap     = wrap_q;
  assign retired      = ret_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a ROM model and a queue
// of expected fetch addresses popped as instructions reach the IR.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [D-1:0]     start_addr;
  logic             busy, done, rom_wrap;
  logic [CNT_W-1:0] retired;

  logic [IW-1:0] rom [0:(1<<D)-1];
  logic [D-1:0]  exp_q [$];
  int            total  = 0;
  int            passed = 0;

  fetch_sequencer_if bus ();

  assign bus.mach_code = rom[bus.prog_ctr];

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .rom_wrap   (rom_wrap),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one advance: the next queued address must now sit in the IR
  task automatic issue();
    logic [D-1:0] a;
    step();
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'd1, 32'd0);
    end else begin
      a = exp_q.pop_front();
      chk("issue_valid", 32'(bus.ir_valid), 32'd1);
      chk("issue_pc", 32'(bus.ir_pc), 32'(a));
      chk("issue_ir", 32'(bus.ir), 32'(rom[a]));
    end
  endtask

  task automatic chk_reset();
    chk("rst_pc", 32'(bus.prog_ctr), 32'd0);
    chk("rst_ir", 32'(bus.ir), 32'd0);
    chk("rst_valid", 32'(bus.ir_valid), 32'd0);
    chk("rst_irpc", 32'(bus.ir_pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(rom_wrap), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << D); i++) rom[i] = IW'(i * 37 + 5);
    rom[0] = 9'h07E;
    rom[1] = 9'h066;
    rom[2] = 9'h07A;
    rom[3] = 9'h1DE;

    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    bus.stall = 1'b0;
    bus.halt = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_abs = 1'b0;
    bus.branch_target = '0;
    bus.branch_off = '0;
    step();
    step();
    reset = 1'b0;
    chk_reset();

    // straight line from 0
    start = 1'b1;
    start_addr = 12'h000;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pc", 32'(bus.prog_ctr), 32'h000);
    chk("start_valid", 32'(bus.ir_valid), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(D'(i));
    issue();
    chk("ret_first", 32'(retired), 32'd0);
    issue();
    chk("ret_second", 32'(retired), 32'd1);

    // stall freezes everything
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(bus.prog_ctr), 32'h002);
      chk("stall_ir", 32'(bus.ir), 32'h066);
      chk("stall_ret", 32'(retired), 32'd1);
    end
    bus.stall = 1'b0;
    issue();
    issue();
    chk("ret_line", 32'(retired), 32'd3);

    // absolute branch
    bus.branch_taken = 1'b1;
    bus.branch_abs = 1'b1;
    bus.branch_target = 12'h100;
    step();
    bus.branch_taken = 1'b0;
    chk("abs_valid", 32'(bus.ir_valid), 32'd0);
    chk("abs_pc", 32'(bus.prog_ctr), 32'h100);
    chk("abs_ret", 32'(retired), 32'd4);
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h101);
    exp_q.push_back(12'h102);
    issue();
    chk("ret_bubble", 32'(retired), 32'd4);
    start = 1'b1;
    start_addr = 12'h555;
    issue();
    start = 1'b0;
    chk("start_in_run", 32'(retired), 32'd5);
    issue();

    // relative branch backwards from 0x102
    bus.branch_taken = 1'b1;
    bus.branch_abs = 1'b0;
    bus.branch_off = 8'hFE;
    step();
    bus.branch_taken = 1'b0;
    chk("rel_pc", 32'(bus.prog_ctr), 32'h100);
    chk("rel_valid", 32'(bus.ir_valid), 32'd0);
    chk("rel_ret", 32'(retired), 32'd7);
    exp_q.push_back(12'h100);
    issue();

    // halt
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_valid", 32'(bus.ir_valid), 32'd0);
    chk("halt_ret", 32'(retired), 32'd8);
    chk("halt_pc", 32'(bus.prog_ctr), 32'h101);
    step();
    chk("done_hold", 32'(done), 32'd1);

    // restart at 0x010
    start = 1'b1;
    start_addr = 12'h010;
    step();
    start = 1'b0;
    chk("re_busy", 32'(busy), 32'd1);
    chk("re_done", 32'(done), 32'd0);
    chk("re_ret", 32'(retired), 32'd0);
    chk("re_pc", 32'(bus.prog_ctr), 32'h010);
    exp_q.push_back(12'h010);
    issue();

    // jump to 0 then relative -2 wraps to 0xFFE
    bus.branch_taken = 1'b1;
    bus.branch_abs = 1'b1;
    bus.branch_target = 12'h000;
    step();
    chk("abs0_pc", 32'(bus.prog_ctr), 32'h000);
    exp_q.push_back(12'h000);
    bus.branch_taken = 1'b0;
    issue();
    bus.branch_taken = 1'b1;
    bus.branch_abs = 1'b0;
    bus.branch_off = 8'hFE;
    step();
    bus.branch_taken = 1'b0;
    chk("relwrap_pc", 32'(bus.prog_ctr), 32'hFFE);
    chk("relwrap_ret", 32'(retired), 32'd2);

    // end of ROM
    exp_q.push_back(12'hFFE);
    exp_q.push_back(12'hFFF);
    issue();
    issue();
    chk("wrap_flag", 32'(rom_wrap), 32'd1);
    chk("wrap_pc", 32'(bus.prog_ctr), 32'h000);
    chk("wrap_done_early", 32'(done), 32'd0);
    chk("wrap_ret", 32'(retired), 32'd3);
    step();
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_valid", 32'(bus.ir_valid), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_ret_end", 32'(retired), 32'd4);

    // restart at 0xFFE, then reset mid-run
    start = 1'b1;
    start_addr = 12'hFFE;
    step();
    start = 1'b0;
    chk("re2_wrap_clr", 32'(rom_wrap), 32'd0);
    chk("re2_busy", 32'(busy), 32'd1);
    exp_q.push_back(12'hFFE);
    issue();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
